// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register target.
//   i2c_state_t      : protocol FSM states
//   ACK / NACK       : SDA levels on the ninth bit of a byte
//   DEFAULT_DEV_ADDR : 7-bit bus address used unless overridden
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG,
        REG_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        WAIT_STOP
    } i2c_state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h50;

endpackage

// File: rtl/i2c_line_sync.sv
// Brings the raw SCL/SDA pins into the clk domain and decodes bus events.
//   clk, rst_n        : system clock, asynchronous active-low reset
//   scl_in, sda_in    : raw pin levels, asynchronous to clk
//   sda               : synchronized SDA level, aligned with the strobes
//   scl_rise/scl_fall : one-clk strobes on synchronized SCL edges
//   start/stop        : one-clk strobes for SDA fall/rise while SCL is high
module i2c_line_sync
    import i2c_pkg::*;
#(
    parameter int MIN_HALF = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    // Pin-to-strobe latency is three clk edges; the target must be able to
    // react to an SCL fall and settle SDA well before the next SCL rise.
    if (MIN_HALF < 4) begin : g_min_half
        $error("i2c_line_sync: MIN_HALF must be at least 4");
    end

    logic scl_p0, scl_p1, scl_p2;
    logic sda_p0, sda_p1, sda_p2;

    // p0/p1: two-flop synchronizer; p2: previous synchronized level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_p0 <= 1'b1;
            scl_p1 <= 1'b1;
            scl_p2 <= 1'b1;
            sda_p0 <= 1'b1;
            sda_p1 <= 1'b1;
            sda_p2 <= 1'b1;
        end else begin
            scl_p0 <= scl_in;
            scl_p1 <= scl_p0;
            scl_p2 <= scl_p1;
            sda_p0 <= sda_in;
            sda_p1 <= sda_p0;
            sda_p2 <= sda_p1;
        end
    end

    assign sda      = sda_p1;
    assign scl_rise = scl_p1 & ~scl_p2;
    assign scl_fall = ~scl_p1 & scl_p2;
    // SCL must be high on both samples so an SDA edge racing an SCL edge
    // is never taken as a bus condition.
    assign start    = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
    assign stop     = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;

endmodule

// File: rtl/i2c_target.sv
// I2C target exposing a register interface: one register byte followed by
// a 16-bit word (MSB byte first) for writes, a 16-bit word for reads.
//   clk, rst_n      : system clock, asynchronous active-low reset
//   scl_in, sda_in  : raw bus pin levels
//   sda_oe          : 1 pulls SDA low, 0 releases it (open drain)
//   reg_addr        : register pointer, last register byte received
//   wr_data, wr_stb : write word and its one-clk strobe
//   rd_stb, rd_data : read request strobe; rd_data sampled one clk later
//   busy            : addressed, from address match until START/STOP
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR,
    parameter int         MIN_HALF = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic [7:0]  reg_addr,
    output logic [15:0] wr_data,
    output logic        wr_stb,
    output logic        rd_stb,
    input  logic [15:0] rd_data,
    output logic        busy
);

    logic sda, scl_rise, scl_fall, start, stop;

    i2c_line_sync #(.MIN_HALF(MIN_HALF)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    i2c_state_t  state, state_n;
    logic [2:0]  bit_cnt, cnt_n;
    logic [6:0]  shift, shift_n;      // bit 0 holds R/W after the address byte
    logic [1:0]  byte_idx, byte_n;
    logic        phase, phase_n;      // ack bit: 0 before its SCL rise, 1 after
    logic [15:0] rd_shift, rd_shift_n;
    logic        rd_load;
    logic [7:0]  hi_byte, hi_n;
    logic        oe_n, busy_n, wr_stb_n, rd_stb_n;
    logic [7:0]  reg_addr_n;
    logic [15:0] wr_data_n;
    logic [7:0]  rx_byte;

    assign rx_byte = {shift, sda};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            shift    <= 7'd0;
            byte_idx <= 2'd0;
            phase    <= 1'b0;
            rd_shift <= 16'h0000;
            rd_load  <= 1'b0;
            hi_byte  <= 8'h00;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            reg_addr <= 8'h00;
            wr_data  <= 16'h0000;
            wr_stb   <= 1'b0;
            rd_stb   <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= cnt_n;
            shift    <= shift_n;
            byte_idx <= byte_n;
            phase    <= phase_n;
            rd_shift <= rd_shift_n;
            rd_load  <= rd_stb;
            hi_byte  <= hi_n;
            sda_oe   <= oe_n;
            busy     <= busy_n;
            reg_addr <= reg_addr_n;
            wr_data  <= wr_data_n;
            wr_stb   <= wr_stb_n;
            rd_stb   <= rd_stb_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = bit_cnt;
        shift_n    = shift;
        byte_n     = byte_idx;
        phase_n    = phase;
        rd_shift_n = rd_shift;
        hi_n       = hi_byte;
        oe_n       = sda_oe;
        busy_n     = busy;
        reg_addr_n = reg_addr;
        wr_data_n  = wr_data;
        wr_stb_n   = 1'b0;
        rd_stb_n   = 1'b0;

        // The read word is captured the clk after rd_stb, long before the
        // first data bit goes out.
        if (rd_load) rd_shift_n = rd_data;

        if (stop) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else if (start) begin
            state_n = ADDR;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
            cnt_n   = 3'd0;
        end else begin
            case (state)
                ADDR, REG, WDATA: begin
                    if (scl_rise) begin
                        shift_n = rx_byte[6:0];
                        cnt_n   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            phase_n = 1'b0;
                            if (state == ADDR) begin
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    busy_n   = 1'b1;
                                    rd_stb_n = rx_byte[0];
                                    state_n  = ADDR_ACK;
                                end else begin
                                    state_n = WAIT_STOP;
                                end
                            end else if (state == REG) begin
                                reg_addr_n = rx_byte;
                                state_n    = REG_ACK;
                            end else if (byte_idx == 2'd0) begin
                                hi_n    = rx_byte;
                                state_n = WDATA_ACK;
                            end else if (byte_idx == 2'd1) begin
                                wr_data_n = {hi_byte, rx_byte};
                                wr_stb_n  = 1'b1;
                                state_n   = WDATA_ACK;
                            end else begin
                                // Word already complete: leave SDA released (NACK).
                                state_n = WAIT_STOP;
                            end
                        end
                    end
                end

                ADDR_ACK, REG_ACK, WDATA_ACK: begin
                    if (scl_rise) phase_n = 1'b1;
                    if (scl_fall) begin
                        if (!phase) begin
                            oe_n = ~ACK;
                        end else begin
                            oe_n  = 1'b0;
                            cnt_n = 3'd0;
                            if (state == ADDR_ACK && shift[0]) begin
                                state_n = RDATA;
                                byte_n  = 2'd0;
                                oe_n    = ~rd_shift[15];
                            end else if (state == ADDR_ACK) begin
                                state_n = REG;
                            end else if (state == REG_ACK) begin
                                state_n = WDATA;
                                byte_n  = 2'd0;
                            end else begin
                                state_n = WDATA;
                                byte_n  = byte_idx + 2'd1;
                            end
                        end
                    end
                end

                RDATA: begin
                    if (scl_rise) begin
                        rd_shift_n = {rd_shift[14:0], 1'b0};
                        cnt_n      = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            phase_n = 1'b0;
                            state_n = RDATA_ACK;
                        end
                    end
                    if (scl_fall) oe_n = ~rd_shift[15];
                end

                RDATA_ACK: begin
                    if (scl_fall && !phase) oe_n = 1'b0;
                    if (scl_rise) begin
                        if (sda == NACK || byte_idx != 2'd0) begin
                            state_n = WAIT_STOP;
                        end else begin
                            phase_n = 1'b1;
                            byte_n  = 2'd1;
                        end
                    end
                    if (scl_fall && phase) begin
                        state_n = RDATA;
                        cnt_n   = 3'd0;
                        oe_n    = ~rd_shift[15];
                    end
                end

                IDLE, WAIT_STOP: ;

                default: state_n = IDLE;
            endcase
        end
    end

endmodule
